// File: rtl/ahb_mem_arbiter.sv
// Round-robin arbiter between instruction fetch (rq0) and load/store (rq1) in front of
// one AHB-Lite memory slave: one single-beat NONSEQ at a time, alignment screen, wait watchdog.
module ahb_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        rq0_req,
  input  logic [31:0] rq0_addr,
  input  logic        rq0_write,
  input  logic [2:0]  rq0_size,
  input  logic [31:0] rq0_wdata,
  output logic        rq0_done,
  output logic [31:0] rq0_rdata,
  output logic        rq0_err,
  input  logic        rq1_req,
  input  logic [31:0] rq1_addr,
  input  logic        rq1_write,
  input  logic [2:0]  rq1_size,
  input  logic [31:0] rq1_wdata,
  output logic        rq1_done,
  output logic [31:0] rq1_rdata,
  output logic        rq1_err,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  state_t        r_state;
  logic          r_last_grant;
  logic          r_winner;
  logic [31:0]   r_addr;
  logic          r_write;
  logic [2:0]    r_size;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_wait_cnt;
  logic [1:0]    r_done;
  logic [1:0]    r_err;
  logic [31:0]   r_rdata [2];

  logic [1:0]    w_req;
  logic [1:0]    w_elig;
  logic          w_pick;
  logic [31:0]   w_sel_addr;
  logic          w_sel_write;
  logic [2:0]    w_sel_size;
  logic [31:0]   w_sel_wdata;
  logic          w_misaligned;
  logic          w_wait_hit;

  // A requester whose done is showing this cycle is not eligible, which lets the
  // other side win first when both keep requesting.
  assign w_req = {rq1_req, rq0_req};
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign w_elig[gi] = w_req[gi] & ~r_done[gi];
  end

  assign w_pick      = (&w_elig) ? ~r_last_grant : w_elig[1];
  assign w_sel_addr  = w_pick ? rq1_addr  : rq0_addr;
  assign w_sel_write = w_pick ? rq1_write : rq0_write;
  assign w_sel_size  = w_pick ? rq1_size  : rq0_size;
  assign w_sel_wdata = w_pick ? rq1_wdata : rq0_wdata;

  assign w_misaligned = (w_sel_size > 3'd2) ||
                        ((w_sel_size == 3'd1) && w_sel_addr[0]) ||
                        ((w_sel_size == 3'd2) && (w_sel_addr[1:0] != 2'b00));

  // Fires on the HREADY-low cycle that would bring the count up to TIMEOUT.
  assign w_wait_hit = !HREADY && (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_winner     <= 1'b0;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_rdata[0]   <= '0;
      r_rdata[1]   <= '0;
    end else begin
      r_done     <= '0;
      r_err      <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_winner     <= w_pick;
            r_last_grant <= w_pick;
            r_addr       <= w_sel_addr;
            r_write      <= w_sel_write;
            r_size       <= w_sel_size;
            r_wdata      <= w_sel_wdata;
            r_wait_cnt   <= '0;
            r_state      <= w_misaligned ? ST_ERR : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_state    <= ST_DATA;
            r_wait_cnt <= '0;
          end else if (w_wait_hit) begin
            r_state          <= ST_IDLE;
            r_wait_cnt       <= '0;
            r_done[r_winner] <= 1'b1;
            r_err[r_winner]  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            r_state            <= ST_IDLE;
            r_done[r_winner]   <= 1'b1;
            r_err[r_winner]    <= (HRESP != 2'b00);
            r_rdata[r_winner]  <= r_write ? 32'h0 : HRDATA;
          end else if (w_wait_hit) begin
            r_state          <= ST_IDLE;
            r_wait_cnt       <= '0;
            r_done[r_winner] <= 1'b1;
            r_err[r_winner]  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        ST_ERR: begin
          r_state          <= ST_IDLE;
          r_done[r_winner] <= 1'b1;
          r_err[r_winner]  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign HSEL   = (r_state == ST_ADDR);
  assign HTRANS = (r_state == ST_ADDR) ? 2'b10 : 2'b00;
  assign HADDR  = r_addr;
  assign HWRITE = r_write;
  assign HSIZE  = r_size;
  assign HWDATA = r_wdata;

  assign rq0_done  = r_done[0];
  assign rq0_err   = r_err[0];
  assign rq0_rdata = r_rdata[0];
  assign rq1_done  = r_done[1];
  assign rq1_err   = r_err[1];
  assign rq1_rdata = r_rdata[1];
endmodule
